regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised integer register file with a built-in busy-bit scoreboard for the pipelined RV32I core. Provides NREAD combinational read ports, one writeback port with optional same-cycle bypass, and an allocation port that issue logic uses to mark destination registers as pending. Sits between decode/issue (reads, allocation) and writeback. Read-after-write and write-after-write hazards are detected here instead of in the hazard unit.

## Interface
- XLEN, 32: data width in bits.
- NREGS, 32: number of architectural registers; power of two, ≥ 2. Register 0 is hardwired to zero.
- NREAD, 2: number of read ports, ≥ 1.
- BYPASS, 1: 1 forwards same-cycle writeback data to the read ports; 0 disables forwarding.
- AW (localparam), $clog2(NREGS): register address width.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- rd_addr  in  NREAD*AW  read addresses; port i at [i*AW +: AW].
- rd_data  out  NREAD*XLEN  read data; port i at [i*XLEN +: XLEN]; combinational.
- rd_busy  out  NREAD  register for port i has a pending write (after bypass).
- alloc_valid  in  1  issue requests reservation of alloc_addr.
- alloc_addr  in  AW  destination to reserve.
- alloc_ready  out  1  reservation can be accepted this cycle; combinational.
- wb_valid  in  1  writeback strobe.
- wb_addr  in  AW  writeback destination.
- wb_data  in  XLEN  writeback value.
- flush  in  1  pipeline flush; clears all busy bits, keeps data.
- busy_count  out  AW+1  number of registers currently busy.

## Operation
- Register 0:
  - Always reads 0.
  - Never busy.
  - Writes are ignored.
  - Allocation to it is accepted (alloc_ready=1) and has no effect.
- Read port i, with a = rd_addr[i]:
  - When BYPASS=1, wb_valid=1, wb_addr==a and a≠0: rd_data=wb_data and rd_busy=0.
  - Otherwise: rd_data=regs[a] and rd_busy=busy[a].
- Writeback (wb_valid=1, wb_addr≠0):
  - regs[wb_addr] ← wb_data.
  - busy[wb_addr] ← 0.
  - A writeback to a non-busy register still writes the data.
- Allocation:
  - alloc_ready = alloc_addr==0, or !busy[alloc_addr], or (wb_valid && wb_addr==alloc_addr). Registers with a pending write stall allocation (WAW).
  - The reservation is accepted when alloc_valid && alloc_ready; then busy[alloc_addr] ← 1.
- Simultaneous events, in priority order:
  - flush beats everything else on the busy bits: all busy bits are cleared and an accepted alloc is discarded. Writeback data is still written.
  - alloc and wb to the same address: busy ends at 1 (the new producer owns the register). Data is written.
- busy_count:
  - Maintained as a counter updated with the set/clear events of each cycle (+1, −1, 0, or 0 after flush).
  - Must equal the popcount of the busy bits at all times.

## Timing
- Reads are zero-latency combinational from rd_addr, wb_* and state.
- A writeback is visible on rd_data in the same cycle when BYPASS=1, and from the next cycle when BYPASS=0.
- alloc and flush take effect on rd_busy, alloc_ready and busy_count in the cycle after the edge.
- Reset: a rising edge with rst_n=0 clears all registers, busy bits and busy_count.
  - After that edge, every rd_data=0, rd_busy=0, alloc_ready=1 and busy_count=0.
  - Reset asserted mid-operation discards all pending reservations and any same-cycle wb or alloc.

## Structure
- Package regfile_pkg holds:
  - Default XLEN and NREGS.
  - The ZERO_REG constant.
  - Typedefs for the register address and data words.
- Sub-module busy_scoreboard holds the NREGS busy bits, busy_count, and the alloc/wb/flush priority logic. The top level holds the data array and the read/bypass muxes.

## Test plan
- Reset, then read x5 and x31 → rd_data=0 and rd_busy=0 on both ports; busy_count=0.
- Alloc x7; next cycle read x7 → rd_busy=1, busy_count=1. Alloc x7 again → alloc_ready=0.
- With x7 busy: wb x7=0xDEADBEEF while port 1 reads x7.
  - BYPASS=1 → same cycle rd_data=0xDEADBEEF, rd_busy=0.
  - Next cycle busy_count=0.
  - BYPASS=0 → old value in the wb cycle, new value in the following cycle.
- wb x0=0x1234 and alloc x0 → reads of x0 stay 0 and not busy; busy_count unchanged.
- Same cycle: alloc x3 and wb x3=0x55 → x3 reads 0x55, rd_busy=1, busy_count unchanged (+1 −1).
- Alloc x1, x2, x4 over 3 cycles → busy_count=3.
  - flush together with alloc x9 → next cycle busy_count=0, x9 not busy.
  - rst_n low mid-stream → all cleared.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and word types for the integer register file and its scoreboard.
package regfile_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);
  localparam int unsigned ZERO_REG = 0;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read, allocation and writeback bundle between issue/writeback and the register file.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS)
);
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  alloc_valid;
  logic [AW-1:0]         alloc_addr;
  logic                  alloc_ready;
  logic                  wb_valid;
  logic [AW-1:0]         wb_addr;
  logic [XLEN-1:0]       wb_data;
  logic                  flush;
  logic [AW:0]           busy_count;

  modport master (
    output rd_addr, alloc_valid, alloc_addr, wb_valid, wb_addr, wb_data, flush,
    input  rd_data, rd_busy, alloc_ready, busy_count
  );

  modport slave (
    input  rd_addr, alloc_valid, alloc_addr, wb_valid, wb_addr, wb_data, flush,
    output rd_data, rd_busy, alloc_ready, busy_count
  );
endinterface

// File: rtl/busy_scoreboard.sv
// Pending-write bits per register plus a running count; flush > alloc > writeback on the busy bits.
module busy_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid_i,
  input  logic [AW-1:0]    alloc_addr_i,
  input  logic             wb_valid_i,
  input  logic [AW-1:0]    wb_addr_i,
  input  logic             flush_i,
  output logic             alloc_ready_o,
  output logic [NREGS-1:0] busy_o,
  output logic [AW:0]      busy_count_o
);
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;
  logic             alloc_nz, wb_nz, alloc_fire, wb_clr, cnt_inc, cnt_dec;

  always_comb begin
    alloc_nz      = alloc_addr_i != AW'(ZERO_REG);
    wb_nz         = wb_addr_i != AW'(ZERO_REG);
    alloc_ready_o = !alloc_nz || !busy_q[alloc_addr_i] ||
                    (wb_valid_i && wb_addr_i == alloc_addr_i);
    alloc_fire    = alloc_valid_i && alloc_ready_o && alloc_nz;
    wb_clr        = wb_valid_i && wb_nz && busy_q[wb_addr_i];
    // Count tracks real bit transitions so it always equals the popcount.
    cnt_inc       = alloc_fire && !busy_q[alloc_addr_i];
    cnt_dec       = wb_clr && !(alloc_fire && alloc_addr_i == wb_addr_i);
    busy_d        = busy_q;
    count_d       = count_q;
    if (flush_i) begin
      busy_d  = '0;
      count_d = '0;
    end else begin
      if (wb_clr)     busy_d[wb_addr_i]    = 1'b0;
      if (alloc_fire) busy_d[alloc_addr_i] = 1'b1;
      count_d = count_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o       = busy_q;
  assign busy_count_o = count_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with combinational read ports, optional writeback bypass, and busy-bit scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input logic               clk,
  input logic               rst_n,
  regfile_scoreboard_if.slave bus
);
  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [NREGS-1:0]           busy;
  logic                       wb_we;

  // x0 is never written, so its reset value of zero holds forever.
  assign wb_we = bus.wb_valid && (bus.wb_addr != AW'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (!rst_n)     regs_q <= '0;
    else if (wb_we) regs_q[bus.wb_addr] <= bus.wb_data;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a   = bus.rd_addr[i*AW +: AW];
    assign hit = (BYPASS != 0) && wb_we && (bus.wb_addr == a);
    assign bus.rd_data[i*XLEN +: XLEN] = hit ? bus.wb_data : regs_q[a];
    assign bus.rd_busy[i]              = !hit && busy[a];
  end

  busy_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_valid_i (bus.alloc_valid),
    .alloc_addr_i  (bus.alloc_addr),
    .wb_valid_i    (bus.wb_valid),
    .wb_addr_i     (bus.wb_addr),
    .flush_i       (bus.flush),
    .alloc_ready_o (bus.alloc_ready),
    .busy_o        (busy),
    .busy_count_o  (bus.busy_count)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector bench: BYPASS=1 and BYPASS=0 instances share stimulus.
module tb_regfile_scoreboard;
  logic clk, rst_n;
  int   errors = 0;
  int   checks = 0;

  regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bif ();
  regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .NREAD(2)) nif ();

  assign nif.rd_addr     = bif.rd_addr;
  assign nif.alloc_valid = bif.alloc_valid;
  assign nif.alloc_addr  = bif.alloc_addr;
  assign nif.wb_valid    = bif.wb_valid;
  assign nif.wb_addr     = bif.wb_addr;
  assign nif.wb_data     = bif.wb_data;
  assign nif.flush       = bif.flush;

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) dut_bp (
    .clk(clk), .rst_n(rst_n), .bus(bif));
  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .bus(nif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  a0, a1;
    logic        av;
    logic [4:0]  aa;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        fl;
    logic [31:0] d0, d1;
    logic [1:0]  bz;
    logic        ar;
    logic [5:0]  cnt;
    logic [31:0] nd1;
    logic        nb1;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst, logic [4:0] a0, logic [4:0] a1, logic av,
                              logic [4:0] aa, logic wv, logic [4:0] wa, logic [31:0] wd,
                              logic fl, logic [31:0] d0, logic [31:0] d1, logic [1:0] bz,
                              logic ar, logic [5:0] cnt, logic [31:0] nd1, logic nb1);
    vec_t v;
    v.rst = rst; v.a0 = a0; v.a1 = a1; v.av = av; v.aa = aa; v.wv = wv; v.wa = wa;
    v.wd = wd; v.fl = fl; v.d0 = d0; v.d1 = d1; v.bz = bz; v.ar = ar; v.cnt = cnt;
    v.nd1 = nd1; v.nb1 = nb1;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step%0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n           = v.rst;
    bif.rd_addr     = {v.a1, v.a0};
    bif.alloc_valid = v.av;
    bif.alloc_addr  = v.aa;
    bif.wb_valid    = v.wv;
    bif.wb_addr     = v.wa;
    bif.wb_data     = v.wd;
    bif.flush       = v.fl;
  endtask

  initial begin
    vec_t idle;
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    //      rst a0  a1 av aa wv wa wd            fl d0            d1            bz    ar cnt nd1           nb1
    vt.push_back(mk(1, 5, 31, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        2'b00, 1, 0, 32'h0,        0));
    vt.push_back(mk(1, 7, 7,  1, 7, 0, 0, 32'h0,        0, 32'h0,        32'h0,        2'b00, 1, 0, 32'h0,        0));
    vt.push_back(mk(1, 7, 7,  1, 7, 0, 0, 32'h0,        0, 32'h0,        32'h0,        2'b11, 0, 1, 32'h0,        1));
    vt.push_back(mk(1, 7, 7,  0, 7, 1, 7, 32'hDEADBEEF, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 1, 32'h0,        1));
    vt.push_back(mk(1, 7, 7,  0, 7, 0, 0, 32'h0,        0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 0, 32'hDEADBEEF, 0));
    vt.push_back(mk(1, 0, 0,  1, 0, 1, 0, 32'h1234,     0, 32'h0,        32'h0,        2'b00, 1, 0, 32'h0,        0));
    vt.push_back(mk(1, 0, 7,  0, 0, 0, 0, 32'h0,        0, 32'h0,        32'hDEADBEEF, 2'b00, 1, 0, 32'hDEADBEEF, 0));
    vt.push_back(mk(1, 3, 3,  1, 3, 0, 0, 32'h0,        0, 32'h0,        32'h0,        2'b00, 1, 0, 32'h0,        0));
    vt.push_back(mk(1, 3, 3,  1, 3, 1, 3, 32'h55,       0, 32'h55,       32'h55,       2'b00, 1, 1, 32'h0,        1));
    vt.push_back(mk(1, 3, 3,  0, 3, 0, 0, 32'h0,        0, 32'h55,       32'h55,       2'b11, 0, 1, 32'h55,       1));
    vt.push_back(mk(1, 1, 3,  1, 1, 1, 3, 32'h66,       0, 32'h0,        32'h66,       2'b00, 1, 1, 32'h55,       1));
    vt.push_back(mk(1, 1, 2,  1, 2, 0, 0, 32'h0,        0, 32'h0,        32'h0,        2'b01, 1, 1, 32'h0,        0));
    vt.push_back(mk(1, 1, 2,  1, 4, 0, 0, 32'h0,        0, 32'h0,        32'h0,        2'b11, 1, 2, 32'h0,        1));
    vt.push_back(mk(1, 4, 9,  1, 9, 0, 0, 32'h0,        1, 32'h0,        32'h0,        2'b01, 1, 3, 32'h0,        0));
    vt.push_back(mk(1, 3, 9,  0, 9, 0, 0, 32'h0,        0, 32'h66,       32'h0,        2'b00, 1, 0, 32'h0,        0));
    vt.push_back(mk(1, 5, 3,  1, 5, 0, 0, 32'h0,        0, 32'h0,        32'h66,       2'b00, 1, 0, 32'h66,       0));
    vt.push_back(mk(0, 5, 8,  1, 6, 1, 8, 32'h77,       0, 32'h0,        32'h77,       2'b01, 1, 1, 32'h0,        0));
    vt.push_back(mk(1, 3, 8,  0, 6, 0, 0, 32'h0,        0, 32'h0,        32'h0,        2'b00, 1, 0, 32'h0,        0));
    vt.push_back(mk(1, 10, 10, 0, 0, 1, 10, 32'hABC,    1, 32'hABC,      32'hABC,      2'b00, 1, 0, 32'h0,        0));
    vt.push_back(mk(1, 10, 10, 0, 0, 0, 0, 32'h0,       0, 32'hABC,      32'hABC,      2'b00, 1, 0, 32'hABC,      0));

    drive(idle);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < vt.size(); k++) begin
      @(negedge clk);
      drive(vt[k]);
      #1;
      chk("rd_data0",   k, bif.rd_data[31:0],  vt[k].d0);
      chk("rd_data1",   k, bif.rd_data[63:32], vt[k].d1);
      chk("rd_busy",    k, 32'(bif.rd_busy),   32'(vt[k].bz));
      chk("alloc_rdy",  k, 32'(bif.alloc_ready), 32'(vt[k].ar));
      chk("busy_count", k, 32'(bif.busy_count),  32'(vt[k].cnt));
      chk("nb_data1",   k, nif.rd_data[63:32], vt[k].nd1);
      chk("nb_busy1",   k, 32'(nif.rd_busy[1]), 32'(vt[k].nb1));
    end

    // Fill every allocatable register, then exercise the full-count corner.
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      drive(idle);
      bif.alloc_valid = 1'b1;
      bif.alloc_addr  = 5'(r);
    end
    @(negedge clk);
    drive(idle);
    bif.rd_addr    = {5'd1, 5'd31};
    bif.alloc_addr = 5'd31;
    #1;
    chk("full_count", 100, 32'(bif.busy_count),  32'd31);
    chk("full_busy",  101, 32'(bif.rd_busy),     32'b11);
    chk("full_rdy31", 102, 32'(bif.alloc_ready), 32'd0);
    bif.alloc_addr = 5'd0;
    #1;
    chk("full_rdy0",  103, 32'(bif.alloc_ready), 32'd1);

    @(negedge clk);
    bif.alloc_valid = 1'b1;
    bif.alloc_addr  = 5'd31;
    bif.wb_valid    = 1'b1;
    bif.wb_addr     = 5'd31;
    bif.wb_data     = 32'hCAFE;
    #1;
    chk("waw_rdy",    104, 32'(bif.alloc_ready), 32'd1);
    @(negedge clk);
    drive(idle);
    bif.rd_addr = {5'd31, 5'd31};
    #1;
    chk("waw_count",  105, 32'(bif.busy_count),  32'd31);
    chk("waw_busy",   106, 32'(bif.rd_busy),     32'b11);
    chk("waw_data",   107, bif.rd_data[31:0],    32'hCAFE);

    bif.flush = 1'b1;
    @(negedge clk);
    drive(idle);
    bif.rd_addr = {5'd31, 5'd16};
    #1;
    chk("flush_count", 108, 32'(bif.busy_count), 32'd0);
    chk("flush_busy",  109, 32'(bif.rd_busy),    32'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
